inst_mem_arbiter: RTL and testbench
===================================

Name: inst_mem_arbiter

Overview:
- Shares one single-port, synchronous-read instruction memory between two requesters: the CPU fetch stage and a program loader (host/debug path).
- The loader writes and reads back program words.
- Sits between the fetch stage/loader and the instruction BRAM; drives the BRAM enable/write/address and routes the 1-cycle-latency read data back to the owning requester.
- Loader has priority; an anti-starvation counter guarantees fetch progress. A lock mode blocks fetch entirely during boot load.

Parameters:
- ADDR_SIZE, 7, MSB of byte address used; word index = addr[ADDR_SIZE:2].
- MAX_BURST, 4, max consecutive loader grants while fetch is pending before fetch is forced one grant; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- load_lock  in  1  1 = fetch blocked, loader-only mode
- fetch_req  in  1  fetch read request
- fetch_addr  in  32  fetch byte address
- fetch_ready  out  1  fetch request granted this cycle
- fetch_rvalid  out  1  fetch_inst valid
- fetch_inst  out  32  fetch read data
- load_req  in  1  loader request
- load_we  in  1  1 = write, 0 = read
- load_addr  in  32  loader byte address
- load_wdata  in  32  loader write data
- load_ready  out  1  loader request granted this cycle
- load_rvalid  out  1  load_rdata valid (reads only)
- load_rdata  out  32  loader read data
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_SIZE-1  BRAM word index
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Single clock. All state is reset asynchronously when rst=0.
- Reset values: fetch_rvalid=0, load_rvalid=0, burst counter=0, state=RUN.
- Grant outputs and mem_* outputs are combinational from the requests and registered state. With no grant: mem_en=0, mem_we=0, ready=0.
- States:
  - RUN: normal arbitration.
  - LOCK: fetch never granted.
  - Entered RUN→LOCK when load_lock=1 is sampled; LOCK→RUN when load_lock=0 is sampled.
  - In the cycle load_lock rises, fetch is already blocked; load_lock is also applied combinationally.
- Arbitration in RUN, one grant per cycle at most:
  - Only one requester active: grant it.
  - Both active: grant loader, unless burst counter == MAX_BURST, in which case grant fetch.
- Burst counter:
  - Increments on each loader grant while fetch_req=1.
  - Clears on any fetch grant, or on a cycle where fetch_req=0.
  - Saturates at MAX_BURST.
- Grant = ready pulse. The requester must hold req/addr/data until it sees ready. Back-to-back grants are allowed every cycle (fully pipelined).
- Read response:
  - The owner's rvalid rises exactly 1 cycle after its read grant, for 1 cycle.
  - fetch_inst and load_rdata both mirror mem_rdata and are meaningful only while their rvalid=1. They have no reset value.
- Writes (load_we=1): mem_we=1 and mem_wdata=load_wdata in the grant cycle. No rvalid is produced.
- Read-after-write to the same address in consecutive cycles returns the new data; this relies on BRAM write-first/sequential ordering, not on the arbiter.
- Address mapping: addr[1:0] ignored; bits above ADDR_SIZE ignored, so addresses wrap modulo 2^(ADDR_SIZE+1) bytes.
- Reset mid-operation: a pending rvalid is dropped immediately; an in-flight response is lost. After release the block starts in RUN, or in LOCK on the first sampled load_lock=1.
- load_req=0 with load_we=1 is ignored.

Optional Feature:
- Macro: INST_MEM_ARB_STATS_EN.
- Defined: adds outputs stat_fetch_grants (32), stat_load_grants (32) and stat_fetch_stalls (32).
  - stat_fetch_stalls counts cycles with fetch_req=1 and fetch_ready=0.
  - All three counters reset to 0, wrap at 2^32, and are cleared synchronously by an extra input stat_clr (1).
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Fetch-only stream at addresses 0x0, 0x4, 0x8, mem holds 0x11, 0x22, 0x33 → fetch_ready every cycle; fetch_rvalid on cycles 1–3 with fetch_inst 0x11, 0x22, 0x33; load_rvalid stays 0.
- load_lock=1, loader writes 0xDEADBEEF to 0x10 while fetch_req=1 → fetch_ready=0 throughout; mem_we=1 with mem_addr=4. After lock release, fetch of 0x10 returns 0xDEADBEEF.
- Both requesting continuously, MAX_BURST=4 → grant pattern L,L,L,L,F repeating.
- Loader write to byte address 0x200 with ADDR_SIZE=7 → mem_addr=0 (wrap). Load address 0x13 → mem_addr=4.
- Assert rst=0 in the cycle after a fetch grant → fetch_rvalid=0 immediately; after release, no stale rvalid and the burst counter is 0.
- With INST_MEM_ARB_STATS_EN: 10-cycle contention run gives load_grants=8, fetch_grants=2, fetch_stalls=8. Pulsing stat_clr zeroes all three counters.

Source files
------------

// File: rtl/inst_mem_arbiter.sv
// ============================================================================
//  Module   : inst_mem_arbiter
//  Purpose  : Shares a single-port synchronous-read instruction BRAM between
//             the fetch stage and the program loader. The loader has priority,
//             a burst counter keeps fetch from starving, and lock mode blocks
//             fetch. Optional counters: define INST_MEM_ARB_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_arbiter #(
    parameter int ADDR_SIZE = 7,
    parameter int MAX_BURST = 4
) (
`ifdef INST_MEM_ARB_STATS_EN
    input  logic                   stat_clr,
    output logic [31:0]            stat_fetch_grants,
    output logic [31:0]            stat_load_grants,
    output logic [31:0]            stat_fetch_stalls,
`endif
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_lock,
    input  logic                   fetch_req,
    input  logic [31:0]            fetch_addr,
    output logic                   fetch_ready,
    output logic                   fetch_rvalid,
    output logic [31:0]            fetch_inst,
    input  logic                   load_req,
    input  logic                   load_we,
    input  logic [31:0]            load_addr,
    input  logic [31:0]            load_wdata,
    output logic                   load_ready,
    output logic                   load_rvalid,
    output logic [31:0]            load_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_SIZE-2:0]   mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

    state_t     r_state;
    logic [7:0] r_burst;
    logic       r_fetch_rvalid;
    logic       r_load_rvalid;

    logic w_lock;
    logic w_fetch_act;
    logic w_burst_full;
    logic w_load_gnt;
    logic w_fetch_gnt;

    // Lock takes effect in the very cycle load_lock rises, before the state updates.
    always_comb begin
        w_lock       = load_lock | (r_state == LOCK);
        w_fetch_act  = fetch_req & ~w_lock;
        w_burst_full = (r_burst == c_max_burst);
        w_load_gnt   = load_req & ~(w_fetch_act & w_burst_full);
        w_fetch_gnt  = w_fetch_act & ~w_load_gnt;
    end

    assign fetch_ready  = w_fetch_gnt;
    assign load_ready   = w_load_gnt;
    assign mem_en       = w_fetch_gnt | w_load_gnt;
    assign mem_we       = w_load_gnt & load_we;
    assign mem_addr     = w_load_gnt ? load_addr[ADDR_SIZE:2] : fetch_addr[ADDR_SIZE:2];
    assign mem_wdata    = load_wdata;

    assign fetch_rvalid = r_fetch_rvalid;
    assign load_rvalid  = r_load_rvalid;
    assign fetch_inst   = mem_rdata;
    assign load_rdata   = mem_rdata;

    // Byte-lane and out-of-range address bits are deliberately dropped.
    logic w_unused_addr;
    assign w_unused_addr = ^{fetch_addr[31:ADDR_SIZE+1], fetch_addr[1:0],
                             load_addr[31:ADDR_SIZE+1], load_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= RUN;
            r_burst        <= 8'd0;
            r_fetch_rvalid <= 1'b0;
            r_load_rvalid  <= 1'b0;
        end else begin
            case (r_state)
                RUN:     r_state <= load_lock ? LOCK : RUN;
                LOCK:    r_state <= load_lock ? LOCK : RUN;
                default: r_state <= RUN;
            endcase

            if (w_fetch_gnt || !fetch_req)
                r_burst <= 8'd0;
            else if (w_load_gnt && !w_burst_full)
                r_burst <= r_burst + 8'd1;

            r_fetch_rvalid <= w_fetch_gnt;
            r_load_rvalid  <= w_load_gnt & ~load_we;
        end
    end

`ifdef INST_MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetch_grants <= 32'd0;
            stat_load_grants  <= 32'd0;
            stat_fetch_stalls <= 32'd0;
        end else if (stat_clr) begin
            stat_fetch_grants <= 32'd0;
            stat_load_grants  <= 32'd0;
            stat_fetch_stalls <= 32'd0;
        end else begin
            if (w_fetch_gnt)
                stat_fetch_grants <= stat_fetch_grants + 32'd1;
            if (w_load_gnt)
                stat_load_grants <= stat_load_grants + 32'd1;
            if (fetch_req && !w_fetch_gnt)
                stat_fetch_stalls <= stat_fetch_stalls + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_arbiter.sv
// ============================================================================
//  Module   : tb_inst_mem_arbiter
//  Purpose  : Self-checking bench for inst_mem_arbiter with a BRAM model and
//             a read-response scoreboard (ADDR_SIZE=7, MAX_BURST=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_lock, fetch_req, load_req, load_we;
    logic [31:0] fetch_addr, load_addr, load_wdata;
    logic        fetch_ready, fetch_rvalid, load_ready, load_rvalid;
    logic [31:0] fetch_inst, load_rdata;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        stat_clr;
    logic        preload;
`ifdef INST_MEM_ARB_STATS_EN
    logic [31:0] stat_fetch_grants, stat_load_grants, stat_fetch_stalls;
`endif

    always #5 clk = ~clk;

    inst_mem_arbiter #(.ADDR_SIZE(7), .MAX_BURST(4)) dut (
`ifdef INST_MEM_ARB_STATS_EN
        .stat_clr          (stat_clr),
        .stat_fetch_grants (stat_fetch_grants),
        .stat_load_grants  (stat_load_grants),
        .stat_fetch_stalls (stat_fetch_stalls),
`endif
        .clk          (clk),
        .rst          (rst),
        .load_lock    (load_lock),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_ready  (fetch_ready),
        .fetch_rvalid (fetch_rvalid),
        .fetch_inst   (fetch_inst),
        .load_req     (load_req),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_wdata   (load_wdata),
        .load_ready   (load_ready),
        .load_rvalid  (load_rvalid),
        .load_rdata   (load_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h0000_0011;
            1:       return 32'h0000_0022;
            2:       return 32'h0000_0033;
            default: return 32'hA500_0000 | 32'(i);
        endcase
    endfunction

    // Write-first single-port BRAM with one cycle read latency.
    logic [31:0] bram [64];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) bram[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= bram[mem_addr];
        end
    end

    typedef struct {
        logic        lk, fr;  logic [31:0] fa;
        logic        lr, lw;  logic [31:0] la, wd;
        logic        clr;
        logic        e_fr, e_lr, e_en, e_we; logic [5:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic lk, input logic fr, input logic [31:0] fa,
                                input logic lr, input logic lw, input logic [31:0] la,
                                input logic [31:0] wd, input logic clr,
                                input logic efr, input logic elr, input logic een,
                                input logic ewe, input logic [5:0] ea);
        vec_t v;
        v.lk = lk; v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.la = la; v.wd = wd;
        v.clr = clr; v.e_fr = efr; v.e_lr = elr; v.e_en = een; v.e_we = ewe; v.e_addr = ea;
        return v;
    endfunction

    int          errors = 0;
    int          checks = 0;
    logic [31:0] shadow [64];
    logic [31:0] fq [$];
    logic [31:0] lq [$];
    vec_t        tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t idle(input logic clr);
        return mk(0, 0, 0, 0, 0, 0, 0, clr, 0, 0, 0, 0, 6'd0);
    endfunction

    task automatic step(input vec_t v, input string tag);
        logic [31:0] e;
        @(posedge clk); #1;
        load_lock = v.lk; fetch_req = v.fr; fetch_addr = v.fa;
        load_req = v.lr; load_we = v.lw; load_addr = v.la; load_wdata = v.wd;
        stat_clr = v.clr;
        @(negedge clk);
        chk({tag, " fetch_rvalid"}, 32'(fetch_rvalid), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            e = fq.pop_front();
            if (fetch_rvalid) chk({tag, " fetch_inst"}, fetch_inst, e);
        end
        chk({tag, " load_rvalid"}, 32'(load_rvalid), 32'(lq.size() != 0));
        if (lq.size() != 0) begin
            e = lq.pop_front();
            if (load_rvalid) chk({tag, " load_rdata"}, load_rdata, e);
        end
        chk({tag, " fetch_ready"}, 32'(fetch_ready), 32'(v.e_fr));
        chk({tag, " load_ready"},  32'(load_ready),  32'(v.e_lr));
        chk({tag, " mem_en"},      32'(mem_en),      32'(v.e_en));
        chk({tag, " mem_we"},      32'(mem_we),      32'(v.e_we));
        if (v.e_en) chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
        if (v.e_we) chk({tag, " mem_wdata"}, mem_wdata, v.wd);
        if (v.e_fr) fq.push_back(shadow[v.fa[7:2]]);
        if (v.e_lr && !v.lw) lq.push_back(shadow[v.la[7:2]]);
        if (v.e_lr && v.lw) shadow[v.la[7:2]] = v.wd;
    endtask

    task automatic set_idle();
        load_lock = 0; fetch_req = 0; fetch_addr = 0; load_req = 0;
        load_we = 0; load_addr = 0; load_wdata = 0; stat_clr = 0;
    endtask

    task automatic mid_reset(input string tag);
        @(posedge clk); #1;
        set_idle();
        rst = 1'b0;
        #1;
        chk({tag, " fetch_rvalid dropped"}, 32'(fetch_rvalid), 32'd0);
        chk({tag, " load_rvalid dropped"},  32'(load_rvalid),  32'd0);
        fq.delete();
        lq.delete();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Both requesters active: loader reads word 8, fetch reads word 9.
    function automatic vec_t contend(input logic fetch_wins);
        if (fetch_wins) return mk(0, 1, 32'h24, 1, 0, 32'h20, 0, 0, 1, 0, 1, 0, 6'd9);
        return mk(0, 1, 32'h24, 1, 0, 32'h20, 0, 0, 0, 1, 1, 0, 6'd8);
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        set_idle();
        rst = 1'b0;
        preload = 1'b1;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        chk("reset fetch_rvalid", 32'(fetch_rvalid), 32'd0);
        chk("reset load_rvalid",  32'(load_rvalid),  32'd0);
        chk("reset mem_en",       32'(mem_en),       32'd0);
        @(posedge clk); #1 rst = 1'b1;

        //            lk fr fa       lr lw la        wd            clr efr elr en we addr
        tbl.push_back(mk(0, 1, 32'h0,  0, 0, 32'h0,  32'h0,        0,  1,  0,  1, 0, 6'd0));
        tbl.push_back(mk(0, 1, 32'h4,  0, 0, 32'h0,  32'h0,        0,  1,  0,  1, 0, 6'd1));
        tbl.push_back(mk(0, 1, 32'h8,  0, 0, 32'h0,  32'h0,        0,  1,  0,  1, 0, 6'd2));
        tbl.push_back(idle(0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 1, 32'h10, 32'h1234,     0,  0,  0,  0, 0, 6'd0));
        tbl.push_back(mk(1, 1, 32'h10, 1, 1, 32'h10, 32'hDEADBEEF, 0,  0,  1,  1, 1, 6'd4));
        tbl.push_back(mk(1, 1, 32'h10, 0, 0, 32'h0,  32'h0,        0,  0,  0,  0, 0, 6'd0));
        tbl.push_back(mk(0, 1, 32'h10, 0, 0, 32'h0,  32'h0,        0,  0,  0,  0, 0, 6'd0));
        tbl.push_back(mk(0, 1, 32'h10, 0, 0, 32'h0,  32'h0,        0,  1,  0,  1, 0, 6'd4));
        tbl.push_back(mk(0, 0, 32'h0,  1, 1, 32'h200, 32'hCAFEF00D, 0, 0,  1,  1, 1, 6'd0));
        tbl.push_back(mk(0, 1, 32'h0,  0, 0, 32'h0,  32'h0,        0,  1,  0,  1, 0, 6'd0));
        tbl.push_back(mk(0, 0, 32'h0,  1, 0, 32'h13, 32'h0,        0,  0,  1,  1, 0, 6'd4));
        tbl.push_back(idle(1));
        for (int k = 0; k < 10; k++) tbl.push_back(contend(k % 5 == 4));
        tbl.push_back(idle(0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

`ifdef INST_MEM_ARB_STATS_EN
        chk("stat_load_grants",  stat_load_grants,  32'd8);
        chk("stat_fetch_grants", stat_fetch_grants, 32'd2);
        chk("stat_fetch_stalls", stat_fetch_stalls, 32'd8);
        step(idle(1), "clr");
        step(idle(0), "postclr");
        chk("cleared load_grants",  stat_load_grants,  32'd0);
        chk("cleared fetch_grants", stat_fetch_grants, 32'd0);
        chk("cleared fetch_stalls", stat_fetch_stalls, 32'd0);
`endif

        // Reset right after a fetch grant drops the pending response.
        step(mk(0, 1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 6'd1), "rstF");
        mid_reset("rstF");

        // Reset with a partly built loader burst: counter must restart at 0.
        for (int k = 0; k < 3; k++) step(contend(1'b0), $sformatf("preL%0d", k));
        mid_reset("rstL");
        for (int k = 0; k < 5; k++) step(contend(k == 4), $sformatf("postL%0d", k));
        step(idle(0), "drain");
        step(idle(0), "drain2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
